imem_loader: RTL
================

# imem_loader

Byte-stream program loader that writes instructions and data into the pipeline processor's instruction memory, replacing direct testbench preloading. It accepts a framed byte stream on a valid/ready interface, issues one memory write per payload byte, validates an 8-bit checksum, and controls the processor's run enable. It is the writer for the processor's instruction memory and sits between a host link (UART/JTAG bridge) and `pipeline_processor`.

## Interface
- `ADDR_W`, 4, instruction-memory address width; depth = 2^ADDR_W entries
- `SYNC`, 8'hA5, frame start byte
- `clk`  in  1  clock; all state changes on rising edge
- `rst`  in  1  asynchronous, active-low reset (asserted when 0)
- `in_data`  in  8  stream byte
- `in_valid`  in  1  `in_data` valid
- `in_ready`  out  1  loader accepts byte; handshake = `in_valid & in_ready` at rising edge
- `mem_we`  out  1  instruction-memory write strobe, one cycle per payload byte
- `mem_addr`  out  ADDR_W  write address
- `mem_wdata`  out  8  write data
- `cpu_run`  out  1  1 = processor may run; 0 = processor held in reset
- `done`  out  1  one-cycle pulse, frame loaded and checksum good
- `err`  out  1  one-cycle pulse, checksum mismatch

## Operation
- Frame: `SYNC`, ADDR, LEN, LEN payload bytes, CSUM.
- States: IDLE, ADDR, LEN, DATA, CSUM, RESP.
- IDLE: a byte equal to `SYNC` -> ADDR and clears `cpu_run`. Any other byte is accepted and discarded.
- ADDR: latch `in_data[ADDR_W-1:0]` as the write pointer. Upper bits are ignored but included in the checksum. -> LEN.
- LEN: latch 8-bit count. LEN=0 -> CSUM; otherwise -> DATA.
- DATA: each handshake writes the byte to the pointer, increments the pointer modulo 2^ADDR_W, and decrements the count. The last byte -> CSUM.
- Running sum: 8-bit sum, mod 256, of ADDR, LEN and all payload bytes. It is cleared on SYNC acceptance. The SYNC byte is excluded.
- CSUM: compare the received byte with the running sum, then -> RESP.
  - Match: pulse `done` and set `cpu_run`=1.
  - Mismatch: pulse `err` and keep `cpu_run`=0. Payload bytes already written remain in memory.
- RESP: one cycle with `in_ready`=0, then -> IDLE.
- `in_ready` = 1 in every state except RESP. It is combinational from state.
- An overlong frame (LEN > depth) overwrites by wrap-around. This is not an error.

## Timing
- Reset values:
  - State = IDLE, pointer = 0, count = 0, sum = 0.
  - `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
  - `cpu_run`=0, `done`=0, `err`=0.
  - `in_ready`=1.
- Write latency: `mem_we`, `mem_addr` and `mem_wdata` are registered. They are valid in the cycle after the payload handshake. `mem_we` is 1 for exactly that cycle.
- Back-to-back payload bytes produce back-to-back writes. Gaps in `in_valid` produce gaps in `mem_we`.
- `done`/`err` and the `cpu_run` change are asserted in the cycle after the CSUM handshake. The last `mem_we` precedes or coincides with `done`.
- `cpu_run` falls in the cycle after the SYNC handshake. It holds its value across IDLE and discarded bytes.
- `in_valid` with `in_ready`=0 (RESP) is not consumed. The source must hold the byte.
- Reset mid-frame returns to IDLE immediately (asynchronous):
  - Outputs take their reset values and `cpu_run`=0.
  - Writes already completed are not undone.

## Configuration
- `IMEM_LOADER_CSUM_EN` defined: the CSUM byte and check are compiled in, as described above.
- `IMEM_LOADER_CSUM_EN` undefined:
  - No CSUM state and no running-sum logic. `err` is tied to 0.
  - After the last payload byte, or directly after LEN=0, the FSM goes to RESP. `done` pulses and `cpu_run`=1 in the cycle after that handshake.

## Test plan
- Data load: A5,0A,02,32,19,57 -> writes mem[10]=0x32, mem[11]=0x19 on consecutive cycles; `done`=1 one cycle; `cpu_run`=1.
- Program load: A5,00,03,90,A0,36,69 -> mem[0]=0x90, mem[1]=0xA0, mem[2]=0x36; `done` pulse. While the frame is in flight `cpu_run`=0, then 1 after `done`.
- Bad checksum: A5,00,03,90,A0,36,68 -> the three writes occur; `err` pulses one cycle; `done`=0; `cpu_run`=0.
- Wrap and stall: A5,0F,02,11,22,44 with `in_valid` dropped for 3 cycles between 11 and 22 -> mem[15]=0x11, mem[0]=0x22; `mem_we` gap of 3 cycles; `done` pulse.
- Garbage and empty frame: 00,FF,A5,05,00,05 -> first two bytes discarded; no `mem_we`; `done` pulses; `cpu_run`=1.
- Reset mid-frame: assert `rst`=0 after A5,00,03,90 -> outputs at reset values immediately. A subsequent full valid frame loads correctly. A sent-alone CSUM byte in IDLE is discarded.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: framed byte-stream loader for the pipeline processor's
// instruction memory. Frame = SYNC, ADDR, LEN, LEN payload bytes [, CSUM].
// Optional feature macro: IMEM_LOADER_CSUM_EN
//   defined   -> trailing CSUM byte checked against an 8-bit running sum
//   undefined -> no CSUM byte, every complete frame reports done
module imem_loader #(
    parameter int          ADDR_W = 4,
    parameter logic [7:0]  SYNC   = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_run,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_LEN,
        S_DATA,
`ifdef IMEM_LOADER_CSUM_EN
        S_CSUM,
`endif
        S_RESP
    } state_t;

    // State entered once the payload is exhausted (or LEN was zero)
`ifdef IMEM_LOADER_CSUM_EN
    localparam state_t POST_DATA = S_CSUM;
`else
    localparam state_t POST_DATA = S_RESP;
`endif

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] ptr;
    logic [7:0]        count;
    logic              hs;

`ifdef IMEM_LOADER_CSUM_EN
    logic [7:0]        sum;
`else
    assign err = 1'b0;
`endif

    assign in_ready = (state != S_RESP);
    assign hs       = in_valid & in_ready;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode: advance one field per accepted byte
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (hs && in_data == SYNC) state_next = S_ADDR;
            end
            S_ADDR: begin
                if (hs) state_next = S_LEN;
            end
            S_LEN: begin
                if (hs) state_next = (in_data == 8'd0) ? POST_DATA : S_DATA;
            end
            S_DATA: begin
                if (hs && count == 8'd1) state_next = POST_DATA;
            end
`ifdef IMEM_LOADER_CSUM_EN
            S_CSUM: begin
                if (hs) state_next = S_RESP;
            end
`endif
            S_RESP: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Datapath: pointer/count/sum tracking, registered memory write and status pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr       <= '0;
            count     <= 8'd0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 8'd0;
            cpu_run   <= 1'b0;
            done      <= 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
            err       <= 1'b0;
            sum       <= 8'd0;
`endif
        end else begin
            mem_we <= 1'b0;
            done   <= 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
            err    <= 1'b0;
`endif
            if (hs) begin
                case (state)
                    S_IDLE: begin
                        if (in_data == SYNC) begin
                            cpu_run <= 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
                            sum     <= 8'd0;
`endif
                        end
                    end
                    S_ADDR: begin
                        ptr <= in_data[ADDR_W-1:0];
`ifdef IMEM_LOADER_CSUM_EN
                        sum <= sum + in_data;
`endif
                    end
                    S_LEN: begin
                        count <= in_data;
`ifdef IMEM_LOADER_CSUM_EN
                        sum   <= sum + in_data;
`else
                        if (in_data == 8'd0) begin
                            done    <= 1'b1;
                            cpu_run <= 1'b1;
                        end
`endif
                    end
                    S_DATA: begin
                        mem_we    <= 1'b1;
                        mem_addr  <= ptr;
                        mem_wdata <= in_data;
                        ptr       <= ptr + ADDR_W'(1);
                        count     <= count - 8'd1;
`ifdef IMEM_LOADER_CSUM_EN
                        sum       <= sum + in_data;
`else
                        if (count == 8'd1) begin
                            done    <= 1'b1;
                            cpu_run <= 1'b1;
                        end
`endif
                    end
`ifdef IMEM_LOADER_CSUM_EN
                    S_CSUM: begin
                        if (in_data == sum) begin
                            done    <= 1'b1;
                            cpu_run <= 1'b1;
                        end else begin
                            err     <= 1'b1;
                            cpu_run <= 1'b0;
                        end
                    end
`endif
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule
